load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the MEM-stage control signals and the data memory. It turns one load or store request of byte, half, word or doubleword size into a legal sequence of whole-doubleword accesses. Sub-doubleword stores become a read-modify-write. Results return with a one-cycle response pulse, and the request side stalls the pipeline while the unit is busy.

## Interface
- `WORD`, 64 (from `common.vh`): data and address width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present; accepted when `req_ready`=1.
- `req_ready` out 1: 1 only in IDLE.
- `op_store` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 doubleword.
- `sign_ext` in 1: loads only; sign-extend the result instead of zero-extending it.
- `addr` in WORD: byte address.
- `wdata` in WORD: store data, right-aligned in bits [8·n−1:0].
- `resp_valid` out 1: one-cycle completion pulse.
- `rdata` out WORD: load result, valid with `resp_valid`; 0 otherwise.
- `misalign_err` out 1: valid with `resp_valid`; exists only with the macro.
- `MemRead` out 1: data-memory read enable.
- `MemWrite` out 1: data-memory write enable.
- `mem_addr` out WORD: doubleword-aligned address, `addr & ~7`.
- `mem_data` inout WORD: data bus; driven by this block only in WR, high-Z otherwise.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- Every request is latched on acceptance: op, size, sign_ext, addr, wdata.
- IDLE with `req_valid`:
  - load → RD;
  - store with size 11 → WR;
  - store with size 00, 01 or 10 → RD.
- RD:
  - `MemRead`=1 and `mem_data` is high-Z from this side.
  - The capture register samples `mem_data` at the end of the cycle.
  - Next state is RESP for a load, WR for a store.
- WR:
  - `MemWrite`=1; `mem_data` is driven with the merged doubleword.
  - Memory commits on the posedge ending WR.
  - Next state is RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Lane selection is little-endian: offset o = `addr[2:0]`, byte k = bits [8k+7:8k].
- Load extract:
  - the value is `captured >> 8·o`, truncated to the size;
  - it is zero- or sign-extended to WORD per `sign_ext`.
- Store merge:
  - the selected bytes of `captured` are replaced by the low bytes of `wdata`;
  - all other bytes are preserved;
  - a size-11 store writes `wdata` directly with no read.
- Alignment rules: half needs o[0]=0, word needs o[1:0]=0, doubleword needs o=0. Violations are handled per Configuration.
- `MemRead` and `MemWrite` are never 1 in the same cycle.

## Timing
- Request accepted at the edge ending cycle T. Responses:
  - load → `resp_valid` in T+2;
  - doubleword store → T+2;
  - sub-doubleword store → T+3.
- `req_ready` is 0 from T+1 until the RESP cycle inclusive. The next acceptance is possible in the cycle after RESP.
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0, `rdata`=0, `misalign_err`=0; `MemRead`=0, `MemWrite`=0, `mem_addr`=0; `mem_data` high-Z.
- Reset mid-operation: asserting `rst` immediately drops `MemWrite` and releases `mem_data`. An aborted RMW leaves memory unchanged, and no response is produced.
- A request with `req_valid`=1 outside IDLE is ignored; the requester holds it.

## Configuration
- Macro: `LSU_MISALIGN_CHECK_EN`.
- Defined:
  - a misaligned request goes IDLE → RESP directly, with no `MemRead`/`MemWrite`;
  - `resp_valid`=1, `misalign_err`=1 and `rdata`=0 in T+1;
  - memory is untouched.
- Undefined:
  - the `misalign_err` port is absent;
  - the offset is aligned down to the size boundary (o & ~(n−1)) and the access proceeds normally.

## Structure
- `common.vh` gains:
  - the size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`);
  - the FSM state encodings;
  - `LSU_MISALIGN_CHECK_EN`, left commented out by default.
- One combinational sub-module, `lsu_lane_unit`. It does alignment check, load extract/extend and store merge, taking (size, offset, sign_ext, captured, wdata).
- The FSM, request latch, capture register and tri-state driver stay in `load_store_unit`.

## Test plan
- Memory dword at 0x10 = 0x8877665544332211. Load, size 00, addr 0x13, `sign_ext`=0 → `rdata`=0x44 in T+2, one `MemRead` cycle.
- Same memory. Load, size 01, addr 0x16, `sign_ext`=1 → `rdata`=0xFFFFFFFFFFFF8877.
- Store, size 00, addr 0x11, `wdata`=0xAB → RD then WR; memory at 0x10 becomes 0x887766554433AB11; `resp_valid` in T+3.
- Store, size 11, addr 0x20, `wdata`=0xDEADBEEFCAFEF00D → no `MemRead`; memory is written; `resp_valid` in T+2.
- Assert `rst` during WR of a byte store → `MemWrite` falls immediately, memory unchanged, no `resp_valid`, `req_ready`=1.
- With `LSU_MISALIGN_CHECK_EN`: load, size 10, addr 0x12 → `misalign_err`=1, `rdata`=0 in T+1, no memory enables. Without it → aligned to 0x10, `rdata`=0x44332211.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store sequencer: access sizes, FSM states, alignment helper.
// Latency: none, because this file holds only types and a pure function.
// Backpressure: none. Optional misalignment checking is selected by LSU_MISALIGN_CHECK_EN:
// `define LSU_MISALIGN_CHECK_EN
package load_store_unit_pkg;

    localparam int WORD = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Low offset bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] align_mask(size_e s);
        case (s)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and memory-control bundle between the MEM stage, the LSU and data memory.
// Latency: none, because this file only holds wiring.
// Backpressure: req_ready gates the request side. Responses cannot be stalled. Uses LSU_MISALIGN_CHECK_EN.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            op_store;
    logic [1:0]      size;
    logic            sign_ext;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
    logic            resp_valid;
    logic [WORD-1:0] rdata;
`ifdef LSU_MISALIGN_CHECK_EN
    logic            misalign_err;
`endif
    logic            MemRead;
    logic            MemWrite;
    logic [WORD-1:0] mem_addr;

    // Requester and memory side.
    modport master (
`ifdef LSU_MISALIGN_CHECK_EN
        input  misalign_err,
`endif
        output req_valid, op_store, size, sign_ext, addr, wdata,
        input  req_ready, resp_valid, rdata, MemRead, MemWrite, mem_addr
    );

    // The LSU itself.
    modport slave (
`ifdef LSU_MISALIGN_CHECK_EN
        output misalign_err,
`endif
        input  req_valid, op_store, size, sign_ext, addr, wdata,
        output req_ready, resp_valid, rdata, MemRead, MemWrite, mem_addr
    );

endinterface

// File: rtl/load_store_unit_lane_unit.sv
// Byte-lane logic: alignment check, little-endian load extract/extend, store byte merge.
// Latency: purely combinational.
// Backpressure: none. The misaligned output exists only with LSU_MISALIGN_CHECK_EN.
module lsu_lane_unit
    import load_store_unit_pkg::*;
(
`ifdef LSU_MISALIGN_CHECK_EN
    output logic            misaligned,
`endif
    input  size_e           size,
    input  logic [2:0]      offset,
    input  logic            sign_ext,
    input  logic [WORD-1:0] captured,
    input  logic [WORD-1:0] wdata,
    output logic [WORD-1:0] load_data,
    output logic [WORD-1:0] store_data
);

    logic [2:0]      mask;
    logic [2:0]      off_al;
    logic [5:0]      shamt;
    logic [WORD-1:0] shifted;
    logic [WORD-1:0] wdata_sh;
    logic [7:0]      be_base;
    logic [7:0]      be;

    // Offsets are forced down to the size boundary. When checking is enabled,
    // a misaligned access never reaches the data path, so this is harmless there.
    assign mask     = align_mask(size);
    assign off_al   = offset & ~mask;
    assign shamt    = {off_al, 3'b000};
    assign shifted  = captured >> shamt;
    assign wdata_sh = wdata << shamt;
    assign be       = be_base << off_al;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = |(offset & mask);
`endif

    // Truncate the shifted doubleword to the access size, then zero- or sign-extend it.
    always_comb begin
        load_data = shifted;
        case (size)
            SZ_B:    load_data = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_H:    load_data = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_W:    load_data = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    // Byte enables for the access size, before shifting to the lane offset.
    always_comb begin
        be_base = 8'hFF;
        case (size)
            SZ_B:    be_base = 8'h01;
            SZ_H:    be_base = 8'h03;
            SZ_W:    be_base = 8'h0F;
            default: be_base = 8'hFF;
        endcase
    end

    // Replace the enabled bytes of the read data. A doubleword store enables every byte.
    always_comb begin
        store_data = captured;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) begin
                store_data[8*k +: 8] = wdata_sh[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer that splits byte/half/word/dword requests into whole-dword memory accesses.
// Latency: load and dword store respond in T+2, sub-dword store (RMW) in T+3, misaligned with LSU_MISALIGN_CHECK_EN in T+1.
// Backpressure: req_ready is high only in IDLE. The response is a single-cycle pulse that cannot be stalled.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    inout  wire  [WORD-1:0]     mem_data
);

    state_e          state_q, state_d;
    logic            op_store_q;
    logic            sign_ext_q;
    size_e           size_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic [WORD-1:0] captured_q;
    size_e           lane_size;
    logic [2:0]      lane_offset;
    logic [WORD-1:0] load_data;
    logic [WORD-1:0] store_data;
    logic            accept;
`ifdef LSU_MISALIGN_CHECK_EN
    logic            misaligned;
    logic            misalign_q;
`endif

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    // In IDLE the lane unit checks the incoming request. Otherwise it works on the latched one.
    assign lane_size   = (state_q == ST_IDLE) ? size_e'(bus.size) : size_q;
    assign lane_offset = (state_q == ST_IDLE) ? bus.addr[2:0]     : addr_q[2:0];

    assign bus.mem_addr = {addr_q[WORD-1:3], 3'b000};

    // Drive the data bus only while writing. Reset forces IDLE, so the bus is released at once.
    assign mem_data = (state_q == ST_WR) ? store_data : {WORD{1'bz}};

    lsu_lane_unit u_lane (
`ifdef LSU_MISALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .size       (lane_size),
        .offset     (lane_offset),
        .sign_ext   (sign_ext_q),
        .captured   (captured_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Latch the whole request on acceptance so the requester may change its inputs afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_store_q <= 1'b0;
            sign_ext_q <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else if (accept) begin
            op_store_q <= bus.op_store;
            sign_ext_q <= bus.sign_ext;
            size_q     <= size_e'(bus.size);
            addr_q     <= bus.addr;
            wdata_q    <= bus.wdata;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= misaligned;
`endif
        end
    end

    // Capture the memory doubleword at the end of the read cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            captured_q <= '0;
        end else if (state_q == ST_RD) begin
            captured_q <= mem_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state outputs. Read and write enables come from distinct states.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.resp_valid = 1'b0;
        bus.rdata      = '0;
`ifdef LSU_MISALIGN_CHECK_EN
        bus.misalign_err = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_d = ST_RESP;
                    end else
`endif
                    if (bus.op_store && (size_e'(bus.size) == SZ_D)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                bus.MemRead = 1'b1;
                state_d     = op_store_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                bus.MemWrite = 1'b1;
                state_d      = ST_RESP;
            end
            default: begin
                bus.resp_valid = 1'b1;
                if (!op_store_q) begin
                    bus.rdata = load_data;
                end
`ifdef LSU_MISALIGN_CHECK_EN
                bus.misalign_err = misalign_q;
                if (misalign_q) begin
                    bus.rdata = '0;
                end
`endif
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-level reference memory model.
// Latency: the bench checks response cycle counts against the size/op rules.
// Backpressure: the bench observes req_ready and holds no response.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if lsu_if ();
    wire [63:0] mem_data;

    load_store_unit dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (lsu_if),
        .mem_data (mem_data)
    );

    // Environment memory: 16 doublewords, with a preload port for setup.
    logic [63:0] mem [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = '0;
    logic [63:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_dat;
        else if (lsu_if.MemWrite) mem[lsu_if.mem_addr[6:3]] <= mem_data;
    end

    assign mem_data = lsu_if.MemRead ? mem[lsu_if.mem_addr[6:3]] : 64'bz;

    // Reference model memory.
    logic [63:0] ref_mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int align_off(logic [63:0] a, int n);
        return (int'(a[2:0]) / n) * n;
    endfunction

    function automatic logic [63:0] ref_load(logic [63:0] a, logic [1:0] s, logic sx);
        int n;
        int o;
        logic [63:0] v;
        logic [63:0] d;
        n = 1 << s;
        o = align_off(a, n);
        v = '0;
        d = ref_mem[a[6:3]];
        for (int k = 0; k < n; k++) v[8*k +: 8] = d[8*(o+k) +: 8];
        if (sx && v[8*n-1]) begin
            for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] s, input logic [63:0] wd);
        int n;
        int o;
        logic [63:0] d;
        n = 1 << s;
        o = align_off(a, n);
        d = ref_mem[a[6:3]];
        for (int k = 0; k < n; k++) d[8*(o+k) +: 8] = wd[8*k +: 8];
        ref_mem[a[6:3]] = d;
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        pre_we  = 1'b1;
        pre_idx = 4'(idx);
        pre_dat = val;
        ref_mem[idx] = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one request (called #1 after a posedge) and check everything up to the cycle after RESP.
    task automatic run_req(input logic st, input logic [1:0] s, input logic sx,
                           input logic [63:0] a, input logic [63:0] wd);
        int n, lat_exp, rd_exp, wr_exp, lat, rd_cnt, wr_cnt, both, rdy_busy;
        logic mis, eff_mis, got;
        logic [63:0] exp_rdata;
        logic [3:0] idx;
        n       = 1 << s;
        mis     = (int'(a[2:0]) % n) != 0;
        eff_mis = CHK_EN && mis;
        idx     = a[6:3];
        if (eff_mis) begin
            lat_exp = 1; rd_exp = 0; wr_exp = 0; exp_rdata = '0;
        end else if (st) begin
            lat_exp = (s == 2'b11) ? 2 : 3;
            rd_exp  = (s == 2'b11) ? 0 : 1;
            wr_exp  = 1;
            exp_rdata = '0;
        end else begin
            lat_exp = 2; rd_exp = 1; wr_exp = 0;
            exp_rdata = ref_load(a, s, sx);
        end

        lsu_if.op_store = st;
        lsu_if.size     = s;
        lsu_if.sign_ext = sx;
        lsu_if.addr     = a;
        lsu_if.wdata    = wd;
        lsu_if.req_valid = 1'b1;
        chk("ready_idle", 64'(lsu_if.req_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the DUT must use its latched copy.
        lsu_if.req_valid = 1'b0;
        lsu_if.op_store  = 1'($urandom);
        lsu_if.size      = 2'($urandom);
        lsu_if.sign_ext  = 1'($urandom);
        lsu_if.addr      = {$urandom, $urandom};
        lsu_if.wdata     = {$urandom, $urandom};

        got = 1'b0; lat = 0; rd_cnt = 0; wr_cnt = 0; both = 0; rdy_busy = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (lsu_if.resp_valid) begin
                got = 1'b1;
                lat = c;
            end else begin
                rd_cnt += int'(lsu_if.MemRead);
                wr_cnt += int'(lsu_if.MemWrite);
                if (lsu_if.MemRead && lsu_if.MemWrite) both++;
                if (lsu_if.req_ready) rdy_busy++;
                if (lsu_if.MemRead || lsu_if.MemWrite)
                    chk("mem_addr", lsu_if.mem_addr, {a[63:3], 3'b000});
                @(posedge clk); #1;
            end
        end
        chk("resp_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(lat_exp));
        chk("memread_cycles", 64'(rd_cnt), 64'(rd_exp));
        chk("memwrite_cycles", 64'(wr_cnt), 64'(wr_exp));
        chk("rd_wr_overlap", 64'(both), 64'd0);
        chk("ready_busy", 64'(rdy_busy), 64'd0);
        chk("ready_in_resp", 64'(lsu_if.req_ready), 64'd0);
        chk("rdata", lsu_if.rdata, exp_rdata);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("misalign_err", 64'(lsu_if.misalign_err), 64'(eff_mis));
`endif
        @(posedge clk); #1;
        chk("resp_pulse", 64'(lsu_if.resp_valid), 64'd0);
        chk("rdata_idle", lsu_if.rdata, 64'd0);
        chk("ready_after", 64'(lsu_if.req_ready), 64'd1);
        if (st && !eff_mis) ref_store(a, s, wd);
        chk("mem_dword", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        lsu_if.req_valid = 1'b0;
        lsu_if.op_store  = 1'b0;
        lsu_if.size      = 2'b00;
        lsu_if.sign_ext  = 1'b0;
        lsu_if.addr      = '0;
        lsu_if.wdata     = '0;
        #1;
        for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom});
        preload(2, 64'h8877665544332211);

        // Reset state.
        chk("rst_ready", 64'(lsu_if.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(lsu_if.resp_valid), 64'd0);
        chk("rst_rdata", lsu_if.rdata, 64'd0);
        chk("rst_memread", 64'(lsu_if.MemRead), 64'd0);
        chk("rst_memwrite", 64'(lsu_if.MemWrite), 64'd0);
        chk("rst_mem_addr", lsu_if.mem_addr, 64'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rst_misalign", 64'(lsu_if.misalign_err), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases on the known doubleword at 0x10.
        run_req(1'b0, 2'b00, 1'b0, 64'h13, 64'h0);
        run_req(1'b0, 2'b01, 1'b1, 64'h16, 64'h0);
        run_req(1'b0, 2'b10, 1'b0, 64'h12, 64'h0);
        run_req(1'b0, 2'b10, 1'b1, 64'h14, 64'h0);
        run_req(1'b1, 2'b00, 1'b0, 64'h11, 64'hAB);
        chk("byte_store_result", mem[2], 64'h887766554433AB11);
        run_req(1'b1, 2'b11, 1'b0, 64'h20, 64'hDEADBEEFCAFEF00D);
        chk("dword_store_result", mem[4], 64'hDEADBEEFCAFEF00D);
        run_req(1'b1, 2'b01, 1'b0, 64'h2B, 64'h1234);

        // Reset during the write cycle of a byte store.
        lsu_if.op_store  = 1'b1;
        lsu_if.size      = 2'b00;
        lsu_if.sign_ext  = 1'b0;
        lsu_if.addr      = 64'h1D;
        lsu_if.wdata     = 64'h5A;
        lsu_if.req_valid = 1'b1;
        @(posedge clk); #1;
        lsu_if.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_wr", 64'(lsu_if.MemWrite), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_memwrite", 64'(lsu_if.MemWrite), 64'd0);
        chk("abort_ready", 64'(lsu_if.req_ready), 64'd1);
        chk("abort_resp", 64'(lsu_if.resp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int c = 0; c < 4; c++) begin
                if (lsu_if.resp_valid) stray++;
                @(posedge clk); #1;
            end
            chk("abort_no_resp", 64'(stray), 64'd0);
        end
        chk("abort_mem_kept", mem[3], ref_mem[3]);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            run_req(1'($urandom), 2'($urandom), 1'($urandom),
                    64'($urandom_range(0, 127)), {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
